// File: rtl/jk_excitation_counter_pkg.sv
// Shared helpers for the JK excitation counter: per-bit excitation, load clamp
// and parameter legality predicates.
package jk_excitation_counter_pkg;

    localparam int unsigned MIN_WIDTH = 2;
    localparam int unsigned MAX_WIDTH = 16;

    // Reverse JK characteristic: returns {J, K} that move q to nxt.
    // Don't-cares resolve to 0, so J and K are never both 1.
    function automatic logic [1:0] excite_bit(logic q, logic nxt);
        return {~q & nxt, q & ~nxt};
    endfunction

    // Out-of-range load values saturate to the last legal count.
    function automatic int unsigned clamp_val(int unsigned val, int unsigned modulus);
        return (val < modulus) ? val : modulus - 1;
    endfunction

    function automatic bit width_ok(int unsigned w);
        return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
    endfunction

    function automatic bit modulus_ok(int unsigned w, int unsigned m);
        return (m >= 2) && (m <= (32'd1 << w));
    endfunction

endpackage

// File: rtl/jk_ff_bank.sv
// Bank of JK flip-flops with asynchronous active-low reset to 0.
module jk_ff_bank #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q
);

    // JK characteristic equation applied bitwise on every rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= (j & ~q) | (~k & q);
        end
    end

endmodule

// File: rtl/jk_excitation_counter.sv
// Modulo-N up/down counter whose state lives in a JK flip-flop bank. The next
// state is chosen first and then mapped onto J/K through the excitation table.
module jk_excitation_counter
    import jk_excitation_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10,
    parameter int unsigned WRAPW   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_wrap,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j_vec,
    output logic [WIDTH-1:0] k_vec,
    output logic             tc,
    output logic [WRAPW-1:0] wrap_cnt
);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("jk_excitation_counter: WIDTH must be in 2..16");
    end
    if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
        $error("jk_excitation_counter: MODULUS must be in 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [WRAPW-1:0] WRAP_MAX = '1;

    logic [WIDTH-1:0] nxt;
    logic [1:0]       jk_bit;

    // Next-state selection: load, then count up/down, else hold.
    // q >= MAX_VAL on the up path also recovers an out-of-range upset to 0.
    always_comb begin
        nxt = q;
        if (load) begin
            nxt = WIDTH'(clamp_val(32'(load_val), MODULUS));
        end else if (en && up) begin
            nxt = (q >= MAX_VAL) ? '0 : q + WIDTH'(1);
        end else if (en) begin
            nxt = (q == '0) ? MAX_VAL : q - WIDTH'(1);
        end
    end

    // Per-bit excitation from current to next state.
    always_comb begin
        j_vec  = '0;
        k_vec  = '0;
        jk_bit = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            jk_bit   = excite_bit(q[i], nxt[i]);
            j_vec[i] = jk_bit[1];
            k_vec[i] = jk_bit[0];
        end
    end

    // Terminal count marks the cycle whose edge wraps the count.
    assign tc = en & ~load & ((up & (q == MAX_VAL)) | (~up & (q == '0)));

    // Saturating wrap counter; clear beats a coincident wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_cnt <= '0;
        end else if (clr_wrap) begin
            wrap_cnt <= '0;
        end else if (tc && (wrap_cnt != WRAP_MAX)) begin
            wrap_cnt <= wrap_cnt + WRAPW'(1);
        end
    end

    jk_ff_bank #(
        .WIDTH(WIDTH)
    ) u_bank (
        .clk  (clk),
        .rst_n(rst_n),
        .j    (j_vec),
        .k    (k_vec),
        .q    (q)
    );

endmodule

// File: tb/tb_jk_excitation_counter.sv
// Directed and randomised checks for jk_excitation_counter (WIDTH=4, MODULUS=10).
module tb_jk_excitation_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       clr_wrap = 1'b0;

    logic [3:0] q, j_vec, k_vec;
    logic       tc;
    logic [7:0] wrap_cnt;

    logic [3:0] q_s, j_s, k_s;
    logic       tc_s;
    logic [1:0] wrap_s;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    jk_excitation_counter #(.WIDTH(4), .MODULUS(10), .WRAPW(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_wrap(clr_wrap), .q(q), .j_vec(j_vec), .k_vec(k_vec), .tc(tc),
        .wrap_cnt(wrap_cnt)
    );

    jk_excitation_counter #(.WIDTH(4), .MODULUS(10), .WRAPW(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_wrap(clr_wrap), .q(q_s), .j_vec(j_s), .k_vec(k_s), .tc(tc_s),
        .wrap_cnt(wrap_s)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] model_nxt(input logic [3:0] cq, input logic cen,
                                             input logic cup, input logic cld,
                                             input logic [3:0] lv);
        if (cld) return (lv < 4'd10) ? lv : 4'd9;
        if (cen && cup) return (cq >= 4'd9) ? 4'd0 : cq + 4'd1;
        if (cen) return (cq == 4'd0) ? 4'd9 : cq - 4'd1;
        return cq;
    endfunction

    logic [3:0] pq, pj, pk, exp_q;
    logic       exp_tc;
    logic [7:0] exp_wrap;

    initial begin
        // Test 1: async reset, then count up through one wrap
        #1 rst_n = 1'b0;
        #2;
        check_eq("rst_q", q, 0);
        check_eq("rst_wrap", wrap_cnt, 0);
        #9 rst_n = 1'b1;
        en = 1'b1;
        up = 1'b1;
        #1;
        for (int i = 0; i < 12; i++) begin
            check_eq("up_q", q, i % 10);
            check_eq("up_tc", tc, (i % 10) == 9);
            if (i == 3) begin
                check_eq("up34_j", j_vec, 4'b0100);
                check_eq("up34_k", k_vec, 4'b0011);
            end
            tick();
        end
        check_eq("up_end_q", q, 2);
        check_eq("up_wrap", wrap_cnt, 1);

        // Test 2: load 2 then count down through 0 -> 9
        en = 1'b0;
        load = 1'b1;
        load_val = 4'd2;
        #1;
        check_eq("load_tc", tc, 0);
        tick();
        check_eq("load_q", q, 2);
        load = 1'b0;
        en = 1'b1;
        up = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check_eq("dn_q", q, (i < 3) ? 2 - i : 9);
            check_eq("dn_tc", tc, i == 2);
            if (i == 2) begin
                check_eq("dn09_j", j_vec, 4'b1001);
                check_eq("dn09_k", k_vec, 4'b0000);
            end
            tick();
        end
        check_eq("dn_end_q", q, 8);
        check_eq("dn_wrap", wrap_cnt, 2);

        // Test 3: load clamp beats count at terminal count
        up = 1'b1;
        tick();
        check_eq("pre_clamp_q", q, 9);
        load = 1'b1;
        load_val = 4'd13;
        #1;
        check_eq("clamp_tc", tc, 0);
        check_eq("clamp_j", j_vec, 0);
        check_eq("clamp_k", k_vec, 0);
        tick();
        check_eq("clamp_q", q, 9);
        check_eq("clamp_wrap", wrap_cnt, 2);

        // Test 4: async reset between edges at q=7
        en = 1'b0;
        load_val = 4'd7;
        tick();
        check_eq("ld7_q", q, 7);
        load = 1'b0;
        en = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_q", q, 0);
        check_eq("arst_wrap", wrap_cnt, 0);
        check_eq("arst_wrap_s", wrap_s, 0);
        #2 rst_n = 1'b1;
        #1;
        check_eq("rel_q", q, 0);
        tick();
        check_eq("restart_q", q, 1);

        // Test 5: saturation with WRAPW=2, then clear coincident with tc
        for (int i = 0; i < 50; i++) tick();
        check_eq("sat_q", q, 1);
        check_eq("sat_wrap_s", wrap_s, 3);
        check_eq("sat_wrap", wrap_cnt, 5);
        for (int i = 0; i < 8; i++) tick();
        check_eq("clr_pre_tc", tc_s, 1);
        clr_wrap = 1'b1;
        tick();
        clr_wrap = 1'b0;
        check_eq("clr_wrap_s", wrap_s, 0);
        check_eq("clr_wrap", wrap_cnt, 0);
        check_eq("clr_q", q, 0);

        // Test 6: random run with invariant and model checks
        exp_wrap = wrap_cnt;
        for (int i = 0; i < 300; i++) begin
            en       = 1'($urandom_range(0, 3) != 0);
            up       = 1'($urandom_range(0, 1));
            load     = 1'($urandom_range(0, 7) == 0);
            load_val = 4'($urandom_range(0, 15));
            clr_wrap = 1'($urandom_range(0, 15) == 0);
            #1;
            pq = q;
            pj = j_vec;
            pk = k_vec;
            exp_q  = model_nxt(pq, en, up, load, load_val);
            exp_tc = en & ~load & ((up & (pq == 4'd9)) | (~up & (pq == 4'd0)));
            check_eq("rnd_jk_excl", pj & pk, 0);
            check_eq("rnd_jk_excl_s", j_s & k_s, 0);
            check_eq("rnd_tc", tc, exp_tc);
            check_eq("rnd_tc_s", tc_s, exp_tc);
            if (clr_wrap) exp_wrap = 8'd0;
            else if (exp_tc && exp_wrap != 8'hff) exp_wrap = exp_wrap + 8'd1;
            tick();
            check_eq("rnd_char_eq", q, (pj & ~pq) | (~pk & pq));
            check_eq("rnd_model_q", q, exp_q);
            check_eq("rnd_model_q_s", q_s, exp_q);
            check_eq("rnd_wrap", wrap_cnt, exp_wrap);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
